// File: rtl/ecc_mem_ctrl.sv
// ecc_mem_ctrl: SEC-DED (39,32) SRAM controller with a CPU load/store port, a background scrubber and error counters.
// Define ECC_ERR_LOG_EN to add ue_addr_o/ue_syn_o capture of the most recent uncorrectable error.
module hamming_ecc_unit (
    input  logic [31:0] enc_data_i,
    output logic [38:0] enc_cw_o,
    input  logic [38:0] dec_cw_i,
    output logic [31:0] dec_data_o,
    output logic        s_err_o,
    output logic        d_err_o
`ifdef ECC_ERR_LOG_EN
    ,
    output logic [6:0]  syn_o
`endif
);
    // Codeword bit 0 is overall parity; bits 38:1 are Hamming positions 1..38, check bits at powers of two.
    function automatic logic [38:0] pmask(input int k);
        pmask = '0;
        for (int p = 1; p < 39; p++) pmask[p[5:0]] = ((p >> k) & 1) != 0;
    endfunction

    function automatic logic [38:0] place(input logic [31:0] d);
        int j;
        j = 0;
        place = '0;
        for (int p = 3; p < 39; p++)
            if ((p & (p - 1)) != 0) begin
                place[p[5:0]] = d[j[4:0]];
                j++;
            end
    endfunction

    function automatic logic [31:0] extract(input logic [38:0] cw);
        int j;
        j = 0;
        extract = '0;
        for (int p = 3; p < 39; p++)
            if ((p & (p - 1)) != 0) begin
                extract[j[4:0]] = cw[p[5:0]];
                j++;
            end
    endfunction

    logic [38:0] cw;
    logic [5:0]  syn;
    logic        syn_g;

    always_comb begin
        cw = place(enc_data_i);
        for (int k = 0; k < 6; k++) cw[6'(1 << k)] = ^(cw & pmask(k));
        cw[0] = ^cw[38:1];
        enc_cw_o = cw;
    end

    always_comb begin
        syn = '0;
        for (int k = 0; k < 6; k++) syn[k] = ^(dec_cw_i & pmask(k));
        syn_g = ^dec_cw_i;
        s_err_o = syn_g && syn < 6'd39;
        d_err_o = syn_g ? syn > 6'd38 : syn != '0;
        dec_data_o = extract(dec_cw_i ^ (39'(s_err_o) << syn));
    end

`ifdef ECC_ERR_LOG_EN
    assign syn_o = {syn_g, syn};
`endif
endmodule

module ecc_mem_ctrl #(
    parameter int AW             = 10,
    parameter int SCRUB_INTERVAL = 1024,
    parameter int CNT_W          = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cpu_req_i,
    input  logic             cpu_we_i,
    input  logic [AW-1:0]    cpu_addr_i,
    input  logic [31:0]      cpu_wdata_i,
    output logic             cpu_ready_o,
    output logic             cpu_rvalid_o,
    output logic [31:0]      cpu_rdata_o,
    output logic             cpu_err_o,
    input  logic             scrub_en_i,
    output logic             mem_en_o,
    output logic             mem_we_o,
    output logic [AW-1:0]    mem_addr_o,
    output logic [38:0]      mem_wdata_o,
    input  logic [38:0]      mem_rdata_i,
    output logic [CNT_W-1:0] cnt_ce_o,
    output logic [CNT_W-1:0] cnt_ue_o,
    output logic             irq_ue_o
`ifdef ECC_ERR_LOG_EN
    ,
    output logic [AW-1:0]    ue_addr_o,
    output logic [6:0]       ue_syn_o
`endif
);
    typedef enum logic [1:0] {IDLE, CHK, WB} state_t;
    localparam int TW = $clog2(SCRUB_INTERVAL + 1);

    state_t           state_q;
    logic             run_q, src_cpu_q, pend_q, rvalid_q, err_q, irq_q;
    logic [TW-1:0]    tmr_q;
    logic [AW-1:0]    addr_q, saddr_q;
    logic [31:0]      wb_q, rdata_q;
    logic [CNT_W-1:0] ce_q, ue_q;
    logic [38:0]      enc_cw;
    logic [31:0]      dec_data;
    logic             s_err, d_err, idle, cpu_go, scrub_go, tmr_last;
`ifdef ECC_ERR_LOG_EN
    logic [6:0]       syn;
    logic [AW-1:0]    ue_addr_q;
    logic [6:0]       ue_syn_q;
    assign ue_addr_o = ue_addr_q;
    assign ue_syn_o  = ue_syn_q;
`endif

    hamming_ecc_unit u_ecc (
        .enc_data_i (state_q == WB ? wb_q : cpu_wdata_i),
        .enc_cw_o   (enc_cw),
        .dec_cw_i   (mem_rdata_i),
        .dec_data_o (dec_data),
        .s_err_o    (s_err),
        .d_err_o    (d_err)
`ifdef ECC_ERR_LOG_EN
        ,
        .syn_o      (syn)
`endif
    );

    // run_q keeps the combinational accept path quiet while reset is asserted.
    assign idle     = run_q && state_q == IDLE;
    assign cpu_go   = idle && cpu_req_i;
    assign scrub_go = idle && !cpu_req_i && pend_q && scrub_en_i;
    assign tmr_last = tmr_q == TW'(SCRUB_INTERVAL - 1);

    assign cpu_ready_o  = cpu_go;
    assign mem_en_o     = cpu_go || scrub_go || state_q == WB;
    assign mem_we_o     = (cpu_go && cpu_we_i) || state_q == WB;
    assign mem_addr_o   = !mem_en_o ? '0 : state_q == WB ? addr_q : cpu_go ? cpu_addr_i : saddr_q;
    assign mem_wdata_o  = mem_we_o ? enc_cw : '0;
    assign cpu_rvalid_o = rvalid_q;
    assign cpu_rdata_o  = rdata_q;
    assign cpu_err_o    = err_q;
    assign cnt_ce_o     = ce_q;
    assign cnt_ue_o     = ue_q;
    assign irq_ue_o     = irq_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            run_q     <= 1'b0;
            src_cpu_q <= 1'b0;
            pend_q    <= 1'b0;
            tmr_q     <= '0;
            addr_q    <= '0;
            saddr_q   <= '0;
            wb_q      <= '0;
            rdata_q   <= '0;
            rvalid_q  <= 1'b0;
            err_q     <= 1'b0;
            irq_q     <= 1'b0;
            ce_q      <= '0;
            ue_q      <= '0;
`ifdef ECC_ERR_LOG_EN
            ue_addr_q <= '0;
            ue_syn_q  <= '0;
`endif
        end else begin
            run_q    <= 1'b1;
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
            irq_q    <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (cpu_go && !cpu_we_i) begin
                        state_q   <= CHK;
                        src_cpu_q <= 1'b1;
                        addr_q    <= cpu_addr_i;
                    end else if (scrub_go) begin
                        state_q   <= CHK;
                        src_cpu_q <= 1'b0;
                        addr_q    <= saddr_q;
                    end
                end
                CHK: begin
                    state_q <= s_err ? WB : IDLE;
                    wb_q    <= dec_data;
                    if (src_cpu_q) begin
                        rvalid_q <= 1'b1;
                        rdata_q  <= dec_data;
                        err_q    <= d_err;
                    end else begin
                        saddr_q <= saddr_q + 1'b1;
                    end
                    if (s_err && !(&ce_q)) ce_q <= ce_q + 1'b1;
                    if (d_err) begin
                        irq_q <= 1'b1;
                        if (!(&ue_q)) ue_q <= ue_q + 1'b1;
`ifdef ECC_ERR_LOG_EN
                        ue_addr_q <= addr_q;
                        ue_syn_q  <= syn;
`endif
                    end
                end
                default: state_q <= IDLE;
            endcase
            // The timer freezes while a scrub is pending; dropping scrub_en discards both.
            if (!scrub_en_i) begin
                tmr_q  <= '0;
                pend_q <= 1'b0;
            end else if (scrub_go) begin
                pend_q <= 1'b0;
            end else if (!pend_q) begin
                tmr_q  <= tmr_last ? '0 : tmr_q + 1'b1;
                pend_q <= tmr_last;
            end
        end
    end
endmodule

// File: tb/tb_ecc_mem_ctrl.sv
// tb_ecc_mem_ctrl: directed bench for ecc_mem_ctrl with a behavioural SRAM and backdoor bit flips.
module tb_ecc_mem_ctrl;
    localparam int AW = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cpu_req, cpu_we, cpu_ready, cpu_rvalid, cpu_err, scrub_en;
    logic [AW-1:0] cpu_addr, mem_addr;
    logic [31:0] cpu_wdata, cpu_rdata;
    logic        mem_en, mem_we;
    logic [38:0] mem_wdata, mem_rdata;
    logic [1:0]  cnt_ce, cnt_ue;
    logic        irq_ue;
`ifdef ECC_ERR_LOG_EN
    logic [AW-1:0] ue_addr;
    logic [6:0]    ue_syn;
`endif

    always #5 clk = ~clk;

    ecc_mem_ctrl #(.AW(AW), .SCRUB_INTERVAL(4), .CNT_W(2)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cpu_req_i    (cpu_req),
        .cpu_we_i     (cpu_we),
        .cpu_addr_i   (cpu_addr),
        .cpu_wdata_i  (cpu_wdata),
        .cpu_ready_o  (cpu_ready),
        .cpu_rvalid_o (cpu_rvalid),
        .cpu_rdata_o  (cpu_rdata),
        .cpu_err_o    (cpu_err),
        .scrub_en_i   (scrub_en),
        .mem_en_o     (mem_en),
        .mem_we_o     (mem_we),
        .mem_addr_o   (mem_addr),
        .mem_wdata_o  (mem_wdata),
        .mem_rdata_i  (mem_rdata),
        .cnt_ce_o     (cnt_ce),
        .cnt_ue_o     (cnt_ue),
        .irq_ue_o     (irq_ue)
`ifdef ECC_ERR_LOG_EN
        ,
        .ue_addr_o    (ue_addr),
        .ue_syn_o     (ue_syn)
`endif
    );

    logic [38:0]   mem [8] = '{default: '0};
    int            wr_cnt [8] = '{default: 0};
    logic [AW-1:0] rd_a [32];
    int            rd_t [32];
    int            n_rd = 0, cyc = 0, irq_cnt = 0;
    logic          bd_en = 1'b0;
    logic [AW-1:0] bd_addr = '0;
    logic [38:0]   bd_mask = '0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (irq_ue) irq_cnt <= irq_cnt + 1;
        if (bd_en) mem[bd_addr] <= mem[bd_addr] ^ bd_mask;
        if (mem_en && mem_we) begin
            mem[mem_addr] <= mem_wdata;
            wr_cnt[mem_addr] <= wr_cnt[mem_addr] + 1;
        end
        if (mem_en && !mem_we) begin
            mem_rdata <= mem[mem_addr];
            if (n_rd < 32) begin
                rd_a[n_rd] <= mem_addr;
                rd_t[n_rd] <= cyc;
                n_rd <= n_rd + 1;
            end
        end
    end

    int checks = 0, errors = 0;
    logic [38:0] last_cw, cw3, cw5;
    int base, w;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic flip(input logic [AW-1:0] a, input logic [38:0] m);
        bd_en = 1'b1;
        bd_addr = a;
        bd_mask = m;
        tick();
        bd_en = 1'b0;
    endtask

    task automatic store(input logic [AW-1:0] a, input logic [31:0] d);
        cpu_req = 1'b1;
        cpu_we = 1'b1;
        cpu_addr = a;
        cpu_wdata = d;
        #1;
        chk("st_ready", cpu_ready, 1);
        chk("st_we", {mem_en, mem_we}, 2'b11);
        last_cw = mem_wdata;
        tick();
        cpu_req = 1'b0;
        cpu_we = 1'b0;
    endtask

    task automatic load(input logic [AW-1:0] a, input logic [31:0] d, input logic e, input logic wb,
                        input logic [38:0] cw);
        cpu_req = 1'b1;
        cpu_we = 1'b0;
        cpu_addr = a;
        #1;
        chk("ld_ready", cpu_ready, 1);
        chk("ld_strobe", {mem_en, mem_we}, 2'b10);
        tick();
        cpu_req = 1'b0;
        #1;
        chk("ld_rvalid_early", cpu_rvalid, 0);
        tick();
        #1;
        chk("ld_rvalid", cpu_rvalid, 1);
        chk("ld_err", cpu_err, e);
        if (!e) chk("ld_rdata", cpu_rdata, d);
        chk("ld_wb", mem_we, wb);
        if (wb) begin
            chk("wb_addr", mem_addr, a);
            chk("wb_data", mem_wdata, cw);
        end
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        cpu_req = 1'b1;
        cpu_we = 1'b1;
        cpu_addr = 5;
        cpu_wdata = 32'hFFFF_FFFF;
        scrub_en = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_ready", cpu_ready, 0);
        chk("rst_mem", {mem_en, mem_we}, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_cnt", {cnt_ce, cnt_ue, irq_ue, cpu_rvalid}, 0);
        cpu_req = 1'b0;
        cpu_we = 1'b0;
        scrub_en = 1'b0;
        rst_n = 1'b1;
        tick();
        tick();

        store(0, 32'h0000_0001);
        chk("enc_one", last_cw, 39'h00_0000_000F);
        store(1, 32'h8000_0000);
        chk("enc_msb", last_cw, 39'h41_0000_0014);

        store(5, 32'hDEAD_BEEF);
        cw5 = last_cw;
        load(5, 32'hDEAD_BEEF, 1'b0, 1'b0, '0);
        chk("clean_cnt", {cnt_ce, cnt_ue}, 0);

        store(3, 32'h1234_5678);
        cw3 = last_cw;
        flip(3, 39'h10);
        load(3, 32'h1234_5678, 1'b0, 1'b1, cw3);
        chk("ce_one", cnt_ce, 1);
        chk("mem3_clean", mem[3], cw3);
        load(3, 32'h1234_5678, 1'b0, 1'b0, '0);
        chk("ce_still_one", cnt_ce, 1);

        store(7, 32'hA5A5_5A5A);
        flip(7, 39'h204);
        w = wr_cnt[7];
        load(7, '0, 1'b1, 1'b0, '0);
        chk("irq_pulses", irq_cnt, 1);
        chk("irq_low", irq_ue, 0);
        chk("ue_one", cnt_ue, 1);
        tick();
        chk("ue_no_wb", wr_cnt[7], w);
`ifdef ECC_ERR_LOG_EN
        chk("ue_addr", ue_addr, 7);
        chk("ue_syn", ue_syn, 7'h0B);
`endif

        store(7, 32'hA5A5_5A5A);
        flip(3, 39'h400);
        base = n_rd;
        w = wr_cnt[3];
        scrub_en = 1'b1;
        for (int i = 0; i < 300 && n_rd < base + 9; i++) tick();
        scrub_en = 1'b0;
        repeat (8) tick();
        chk("scrub_reads", n_rd - base, 9);
        for (int i = 0; i < 9; i++) begin
            chk("scrub_addr", rd_a[base + i], 64'(i % 8));
            if (i > 0) chk("scrub_gap", rd_t[base + i] - rd_t[base + i - 1] >= 4, 1);
        end
        chk("scrub_wb_cnt", wr_cnt[3] - w, 1);
        chk("scrub_wb_data", mem[3], cw3);
        chk("scrub_ce", cnt_ce, 2);

        scrub_en = 1'b1;
        base = n_rd;
        for (int i = 0; i < 10; i++) store(3'(2 + (i & 1) * 2), 32'(i));
        #1;
        chk("pend_no_read", n_rd - base, 0);
        chk("pend_read", {mem_en, mem_we}, 2'b10);
        chk("pend_addr", mem_addr, 1);
        tick();
        tick();
        scrub_en = 1'b0;
        tick();

        flip(3, 39'h10_0000);
        load(3, 32'h1234_5678, 1'b0, 1'b1, cw3);
        chk("ce_sat3", cnt_ce, 3);
        flip(3, 39'h10_0000);
        load(3, 32'h1234_5678, 1'b0, 1'b1, cw3);
        chk("ce_sat_hold", cnt_ce, 3);

        flip(5, 39'h1);
        cpu_req = 1'b1;
        cpu_we = 1'b0;
        cpu_addr = 5;
        tick();
        cpu_req = 1'b0;
        tick();
        #1;
        chk("wb_pre_rst", mem_we, 1);
        w = wr_cnt[5];
        rst_n = 1'b0;
        #1;
        chk("rst_wb_we", {mem_en, mem_we}, 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("rst_no_write", wr_cnt[5], w);
        chk("rst_mem5", mem[5], cw5 ^ 39'h1);
        chk("rst_counters", {cnt_ce, cnt_ue}, 0);
        chk("rst_outs", {cpu_rvalid, cpu_err, irq_ue, mem_en, mem_we, cpu_ready}, 0);
        chk("rst_rdata", cpu_rdata, 0);
`ifdef ECC_ERR_LOG_EN
        chk("rst_ue_log", {ue_addr, ue_syn}, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
